// File: rtl/ibex_rf_writeback_buffer.sv
// Register-file writeback arbiter with a deferred ex-write buffer. The write port is registered (1 cycle); stall_o flags a full buffer and ex writes arriving then are dropped with err_o.
// Optional macro IBEX_WB_FORWARD_EN: forward buffered/pending writes to the read ports instead of raising hazard_o.
module ibex_rf_writeback_buffer #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_we_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_we_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [DataWidth-1:0] rf_rdata_a_i,
  input  logic [DataWidth-1:0] rf_rdata_b_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic                 stall_o,
  output logic                 hazard_o,
  output logic                 err_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [4:0]           buf_addr_q [Depth];
  logic [DataWidth-1:0] buf_data_q [Depth];
  logic [Depth-1:0]     buf_vld_q;
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]      count_q;

  logic                 ex_req, lsu_req, full, empty;
  logic                 sel_ex, push, pop, lsu_conflict, err_d;
  logic                 we_d;
  logic [4:0]           waddr_d;
  logic [DataWidth-1:0] wdata_d;

  assign ex_req  = ex_we_i & (ex_waddr_i != 5'd0);
  assign lsu_req = lsu_we_i & (lsu_waddr_i != 5'd0);
  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign stall_o = full;

  // Loads win, then the oldest deferred ex write, then a fresh ex write.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    pop     = 1'b0;
    sel_ex  = 1'b0;
    if (lsu_req) begin
      we_d    = 1'b1;
      waddr_d = lsu_waddr_i;
      wdata_d = lsu_wdata_i;
    end else if (!empty) begin
      pop     = 1'b1;
      we_d    = 1'b1;
      waddr_d = buf_addr_q[rd_ptr_q];
      wdata_d = buf_data_q[rd_ptr_q];
    end else if (ex_req) begin
      sel_ex  = 1'b1;
      we_d    = 1'b1;
      waddr_d = ex_waddr_i;
      wdata_d = ex_wdata_i;
    end
  end

  assign push = ex_req & ~sel_ex & ~full;

  always_comb begin
    lsu_conflict = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (buf_vld_q[i] && (buf_addr_q[i] == lsu_waddr_i)) lsu_conflict = 1'b1;
    end
  end

  assign err_d = (ex_req & full) | (lsu_req & lsu_conflict);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      buf_vld_q <= '0;
    end else begin
      if (pop) begin
        buf_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        buf_vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_addr_q[wr_ptr_q] <= ex_waddr_i;
      buf_data_q[wr_ptr_q] <= ex_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      err_o      <= 1'b0;
    end else begin
      rf_we_o    <= we_d;
      rf_waddr_o <= waddr_d;
      rf_wdata_o <= wdata_d;
      err_o      <= err_d;
    end
  end

`ifdef IBEX_WB_FORWARD_EN
  function automatic logic [PtrW-1:0] age_slot(input logic [PtrW-1:0] base, input int unsigned age);
    int unsigned s;
    s = 32'(base) + age;
    if (s >= Depth) s = s - Depth;
    return PtrW'(s);
  endfunction

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    rdata_a_o = rf_rdata_a_i;
    rdata_b_o = rf_rdata_b_i;
    if (rf_we_o && (rf_waddr_o == raddr_a_i)) rdata_a_o = rf_wdata_o;
    if (rf_we_o && (rf_waddr_o == raddr_b_i)) rdata_b_o = rf_wdata_o;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (buf_vld_q[age_slot(rd_ptr_q, i)] && (buf_addr_q[age_slot(rd_ptr_q, i)] == raddr_a_i))
        rdata_a_o = buf_data_q[age_slot(rd_ptr_q, i)];
      if (buf_vld_q[age_slot(rd_ptr_q, i)] && (buf_addr_q[age_slot(rd_ptr_q, i)] == raddr_b_i))
        rdata_b_o = buf_data_q[age_slot(rd_ptr_q, i)];
    end
    if (raddr_a_i == 5'd0) rdata_a_o = rf_rdata_a_i;
    if (raddr_b_i == 5'd0) rdata_b_o = rf_rdata_b_i;
  end

  assign hazard_o = 1'b0;
`else
  logic hit_a, hit_b;

  always_comb begin
    hit_a = rf_we_o && (rf_waddr_o == raddr_a_i);
    hit_b = rf_we_o && (rf_waddr_o == raddr_b_i);
    for (int unsigned i = 0; i < Depth; i++) begin
      if (buf_vld_q[i] && (buf_addr_q[i] == raddr_a_i)) hit_a = 1'b1;
      if (buf_vld_q[i] && (buf_addr_q[i] == raddr_b_i)) hit_b = 1'b1;
    end
    hit_a = hit_a && (raddr_a_i != 5'd0);
    hit_b = hit_b && (raddr_b_i != 5'd0);
  end

  assign rdata_a_o = rf_rdata_a_i;
  assign rdata_b_o = rf_rdata_b_i;
  assign hazard_o  = hit_a | hit_b;
`endif

endmodule

// File: tb/tb_ibex_rf_writeback_buffer.sv
// Bench for ibex_rf_writeback_buffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_ibex_rf_writeback_buffer;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          ex_we, lsu_we, rf_we_o, stall_o, hazard_o, err_o;
  logic [4:0]    ex_waddr, lsu_waddr, rf_waddr_o, raddr_a, raddr_b;
  logic [DW-1:0] ex_wdata, lsu_wdata, rf_wdata_o, rf_rdata_a, rf_rdata_b, rdata_a_o, rdata_b_o;

  always #5 clk = ~clk;

  ibex_rf_writeback_buffer #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
    .lsu_we_i(lsu_we), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .rf_rdata_a_i(rf_rdata_a), .rf_rdata_b_i(rf_rdata_b),
    .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o),
    .stall_o(stall_o), .hazard_o(hazard_o), .err_o(err_o)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {logic [4:0] addr; logic [DW-1:0] data;} wr_t;
  wr_t           m_q[$];
  logic          m_we, m_err;
  logic [4:0]    m_waddr;
  logic [DW-1:0] m_wdata;

  task automatic model_reset();
    m_q.delete();
    m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_err = 1'b0;
  endtask

  // One clock of the specified behaviour, evaluated on the current inputs.
  task automatic model_clock();
    bit ex_req, lsu_req, full, conflict, ex_taken;
    wr_t e;
    ex_req   = ex_we && (ex_waddr != 0);
    lsu_req  = lsu_we && (lsu_waddr != 0);
    full     = (m_q.size() == DEPTH);
    conflict = 0;
    foreach (m_q[i]) if (m_q[i].addr == lsu_waddr) conflict = 1;
    ex_taken = 0;
    m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    if (lsu_req) begin
      m_we = 1'b1; m_waddr = lsu_waddr; m_wdata = lsu_wdata;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_we = 1'b1; m_waddr = e.addr; m_wdata = e.data;
    end else if (ex_req) begin
      m_we = 1'b1; m_waddr = ex_waddr; m_wdata = ex_wdata; ex_taken = 1;
    end
    if (ex_req && !ex_taken && !full) m_q.push_back({ex_waddr, ex_wdata});
    m_err = (ex_req && !ex_taken && full) || (lsu_req && conflict);
  endtask

  function automatic bit exp_hit(input logic [4:0] ra);
    bit h;
    h = m_we && (m_waddr == ra);
    foreach (m_q[i]) if (m_q[i].addr == ra) h = 1;
    return h && (ra != 0);
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input logic [4:0] ra, input logic [DW-1:0] raw);
`ifdef IBEX_WB_FORWARD_EN
    if (ra == 0) return raw;
    for (int i = m_q.size() - 1; i >= 0; i--) if (m_q[i].addr == ra) return m_q[i].data;
    if (m_we && (m_waddr == ra)) return m_wdata;
    return raw;
`else
    return raw;
`endif
  endfunction

  function automatic logic exp_hazard();
`ifdef IBEX_WB_FORWARD_EN
    return 1'b0;
`else
    return exp_hit(raddr_a) || exp_hit(raddr_b);
`endif
  endfunction

  task automatic drive(input logic lwe, input logic [4:0] la, input logic [DW-1:0] ld,
                       input logic ewe, input logic [4:0] ea, input logic [DW-1:0] ed);
    lsu_we = lwe; lsu_waddr = la; lsu_wdata = ld;
    ex_we = ewe; ex_waddr = ea; ex_wdata = ed;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0);
    raddr_a = 0; raddr_b = 0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    raddr_a = 5'd5;
    #1;
    n_vec++; if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL reset_we got=%0b exp=0", rf_we_o); end
    n_vec++; if (rf_waddr_o !== 5'd0) begin n_err++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr_o); end
    n_vec++; if (rf_wdata_o !== '0) begin n_err++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata_o); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got=%0b exp=0", err_o); end
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%0b exp=0", stall_o); end
    n_vec++; if (hazard_o !== 1'b0) begin n_err++; $display("FAIL reset_hazard got=%0b exp=0", hazard_o); end
    raddr_a = 0;
  endtask

  task automatic test_ex_only();
    drive(0, 0, 0, 1, 5'd5, 32'hA5A5A5A5);
    tick();
    n_vec++; if (rf_we_o !== 1'b1) begin n_err++; $display("FAIL ex_only_we got=%0b exp=1", rf_we_o); end
    n_vec++; if (rf_waddr_o !== 5'd5) begin n_err++; $display("FAIL ex_only_waddr got=%0d exp=5", rf_waddr_o); end
    n_vec++; if (rf_wdata_o !== 32'hA5A5A5A5) begin n_err++; $display("FAIL ex_only_wdata got=%h exp=a5a5a5a5", rf_wdata_o); end
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL ex_only_stall got=%0b exp=0", stall_o); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL ex_only_nobuf got=%0b exp=0", rf_we_o); end
  endtask

  task automatic test_conflict();
    drive(1, 5'd3, 32'h11, 1, 5'd7, 32'h22);
    tick();
    n_vec++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd3 || rf_wdata_o !== 32'h11) begin
      n_err++; $display("FAIL conflict_lsu got=%0b/%0d/%h exp=1/3/11", rf_we_o, rf_waddr_o, rf_wdata_o); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd7 || rf_wdata_o !== 32'h22) begin
      n_err++; $display("FAIL conflict_ex got=%0b/%0d/%h exp=1/7/22", rf_we_o, rf_waddr_o, rf_wdata_o); end
    idle(1);
  endtask

  task automatic test_full();
    drive(1, 5'd1, 32'h100, 1, 5'd8, 32'h88);
    tick();
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL full_stall1 got=%0b exp=0", stall_o); end
    drive(1, 5'd2, 32'h200, 1, 5'd9, 32'hDEAD);
    tick();
    n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL full_stall2 got=%0b exp=1", stall_o); end
    drive(1, 5'd3, 32'h300, 1, 5'd10, 32'hAA);
    raddr_a = 5'd9; rf_rdata_a = '0; raddr_b = 0;
    #1;
`ifdef IBEX_WB_FORWARD_EN
    n_vec++; if (rdata_a_o !== 32'hDEAD) begin n_err++; $display("FAIL fwd_rdata got=%h exp=dead", rdata_a_o); end
    n_vec++; if (hazard_o !== 1'b0) begin n_err++; $display("FAIL fwd_hazard got=%0b exp=0", hazard_o); end
`else
    n_vec++; if (rdata_a_o !== 32'h0) begin n_err++; $display("FAIL fwd_rdata got=%h exp=0", rdata_a_o); end
    n_vec++; if (hazard_o !== 1'b1) begin n_err++; $display("FAIL fwd_hazard got=%0b exp=1", hazard_o); end
`endif
    raddr_a = 0;
    tick();
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL full_err got=%0b exp=1", err_o); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL full_err_pulse got=%0b exp=0", err_o); end
    n_vec++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd8 || rf_wdata_o !== 32'h88) begin
      n_err++; $display("FAIL full_drain8 got=%0b/%0d/%h exp=1/8/88", rf_we_o, rf_waddr_o, rf_wdata_o); end
    tick();
    n_vec++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd9 || rf_wdata_o !== 32'hDEAD) begin
      n_err++; $display("FAIL full_drain9 got=%0b/%0d/%h exp=1/9/dead", rf_we_o, rf_waddr_o, rf_wdata_o); end
    tick();
    n_vec++; if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL full_discard got=%0b exp=0", rf_we_o); end
  endtask

  task automatic test_lsu_conflict();
    drive(1, 5'd1, 32'h1, 1, 5'd4, 32'h44);
    tick();
    drive(1, 5'd4, 32'h55, 0, 0, 0);
    tick();
    n_vec++; if (rf_waddr_o !== 5'd4 || rf_wdata_o !== 32'h55 || err_o !== 1'b1) begin
      n_err++; $display("FAIL lsu_conflict got=%0d/%h/err%0b exp=4/55/err1", rf_waddr_o, rf_wdata_o, err_o); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (rf_waddr_o !== 5'd4 || rf_wdata_o !== 32'h44 || err_o !== 1'b0) begin
      n_err++; $display("FAIL lsu_conflict_drain got=%0d/%h/err%0b exp=4/44/err0", rf_waddr_o, rf_wdata_o, err_o); end
    idle(1);
  endtask

  task automatic test_x0();
    drive(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    raddr_a = 0; rf_rdata_a = 32'h1234;
    #1;
    n_vec++; if (rdata_a_o !== 32'h1234) begin n_err++; $display("FAIL x0_read got=%h exp=1234", rdata_a_o); end
    tick();
    n_vec++; if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL x0_we got=%0b exp=0", rf_we_o); end
    drive(1, 5'd1, 32'h1, 1, 5'd0, 32'hFFFFFFFF);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL x0_nopush got=%0b exp=0", rf_we_o); end
  endtask

  task automatic test_reset_mid();
    drive(1, 5'd1, 32'h1, 1, 5'd12, 32'hC);
    tick();
    drive(1, 5'd2, 32'h2, 1, 5'd13, 32'hD);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_stall got=%0b exp=1", stall_o); end
    rst_ni = 1'b0;
    #1;
    model_reset();
    n_vec++; if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL rstmid_we got=%0b exp=0", rf_we_o); end
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL rstmid_stall got=%0b exp=0", stall_o); end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL rstmid_flush%0d got=%0b exp=0", i, rf_we_o); end
    end
    drive(0, 0, 0, 1, 5'd6, 32'h66);
    tick();
    n_vec++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd6 || rf_wdata_o !== 32'h66) begin
      n_err++; $display("FAIL rstmid_first got=%0b/%0d/%h exp=1/6/66", rf_we_o, rf_waddr_o, rf_wdata_o); end
    idle(1);
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      drive(($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom);
      raddr_a = 5'($urandom_range(0, 7)); raddr_b = 5'($urandom_range(0, 7));
      rf_rdata_a = $urandom; rf_rdata_b = $urandom;
      #1;
      n_vec++; if (stall_o !== (m_q.size() == DEPTH)) begin n_err++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, stall_o, m_q.size() == DEPTH); end
      n_vec++; if (hazard_o !== exp_hazard()) begin n_err++; $display("FAIL rnd_hazard c=%0d got=%0b exp=%0b", c, hazard_o, exp_hazard()); end
      n_vec++; if (rdata_a_o !== exp_rdata(raddr_a, rf_rdata_a)) begin n_err++; $display("FAIL rnd_rdata_a c=%0d got=%h exp=%h", c, rdata_a_o, exp_rdata(raddr_a, rf_rdata_a)); end
      n_vec++; if (rdata_b_o !== exp_rdata(raddr_b, rf_rdata_b)) begin n_err++; $display("FAIL rnd_rdata_b c=%0d got=%h exp=%h", c, rdata_b_o, exp_rdata(raddr_b, rf_rdata_b)); end
      tick();
      n_vec++; if (rf_we_o !== m_we) begin n_err++; $display("FAIL rnd_we c=%0d got=%0b exp=%0b", c, rf_we_o, m_we); end
      if (m_we) begin
        n_vec++; if (rf_waddr_o !== m_waddr || rf_wdata_o !== m_wdata) begin
          n_err++; $display("FAIL rnd_wr c=%0d got=%0d/%h exp=%0d/%h", c, rf_waddr_o, rf_wdata_o, m_waddr, m_wdata); end
      end
      n_vec++; if (err_o !== m_err) begin n_err++; $display("FAIL rnd_err c=%0d got=%0b exp=%0b", c, err_o, m_err); end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    raddr_a = 0; raddr_b = 0; rf_rdata_a = '0; rf_rdata_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_ni = 1'b1;
    test_ex_only();
    test_conflict();
    test_full();
    test_lsu_conflict();
    test_x0();
    test_reset_mid();
    test_random(1500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/ibex_rf_writeback_buffer.md
IBEX_RF_WRITEBACK_BUFFER -- requirements
Module: ibex_rf_writeback_buffer

Interface
REQ-001 SHALL have parameter DataWidth, default 32, register word width.
REQ-002 SHALL have parameter Depth, default 2, deferred-write buffer entries; legal range 2..4.
REQ-003 SHALL have ports clk_i (input, 1, clock) and rst_ni (input, 1, reset); one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ex_we_i, ex_waddr_i[4:0], ex_wdata_i[DataWidth-1:0], all inputs: ALU/CSR result write request.
REQ-005 SHALL have lsu_we_i, lsu_waddr_i[4:0], lsu_wdata_i[DataWidth-1:0], all inputs: load-data write request.
REQ-006 SHALL have rf_we_o, rf_waddr_o[4:0], rf_wdata_o[DataWidth-1:0], all outputs: register file write port.
REQ-007 SHALL have raddr_a_i, raddr_b_i (input, 5 each) and rf_rdata_a_i, rf_rdata_b_i (input, DataWidth each): register file read addresses and raw read data.
REQ-008 SHALL have rdata_a_o, rdata_b_o (output, DataWidth each): read data after forwarding.
REQ-009 SHALL have stall_o (output, 1, buffer full), hazard_o (output, 1, read of pending register), err_o (output, 1, protocol violation).

Function
REQ-010 SHALL drop any request with address 0: no issue, no buffering.
REQ-011 SHALL each cycle select one write source, priority: lsu_we_i, then buffer head (buffer non-empty), then ex_we_i.
REQ-012 SHALL push an ex request into the buffer tail when it is not selected in that cycle.
REQ-013 SHALL pop the buffer head when the buffer head is selected; simultaneous push and pop keeps count unchanged.
REQ-014 SHALL register the selected write into rf_we_o/rf_waddr_o/rf_wdata_o at the next clock edge (1-cycle latency); rf_we_o is 0 when nothing is selected.
REQ-015 SHALL drain ex writes in arrival order; ex writes are never reordered with each other.
REQ-016 SHALL drive stall_o = (count == Depth), combinationally from state.
REQ-017 SHALL, when ex_we_i arrives while stall_o is 1, discard the request and pulse err_o for one cycle (registered).
REQ-018 SHALL, when lsu_we_i targets an address held in a valid buffer entry, still issue the LSU write and pulse err_o for one cycle.
REQ-019 SHALL compute the forwarded value per read port as follows.
- Source priority: youngest valid buffer entry with a matching address, then older entries, then the output register (rf_we_o=1, matching address), else rf_rdata_x_i.
- Address 0 always returns rf_rdata_x_i.
REQ-020 SHALL not forward same-cycle ex_*/lsu_* inputs.
REQ-021 SHALL drive hazard_o = 1 when either read address (nonzero) matches a valid buffer entry or the output register (only when forwarding is compiled out, see Configuration); otherwise 0.

Reset
REQ-022 SHALL on rst_ni low asynchronously clear: buffer count, pointers and valid bits; rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0; err_o=0.
REQ-023 SHALL discard all buffered writes on reset mid-operation; first write after reset release issues normally.
REQ-024 SHALL have stall_o=0 and hazard_o=0 during reset.

Configuration
REQ-025 SHALL use macro IBEX_WB_FORWARD_EN.
- Defined: forwarding per REQ-019; hazard_o tied 0.
- Undefined: rdata_x_o = rf_rdata_x_i unmodified; hazard_o per REQ-021.

Verification
REQ-026 SHALL cover ex-only write: ex_we_i=1, addr 5, data 0xA5A5A5A5 -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xA5A5A5A5; count stays 0.
REQ-027 SHALL cover conflict: lsu (addr 3, 0x11) and ex (addr 7, 0x22) in the same cycle -> cycle+1 writes x3=0x11, cycle+2 writes x7=0x22.
REQ-028 SHALL cover full: lsu_we_i held 3 cycles with ex writes x8, x9 -> stall_o=1 after 2 pushes; a third ex write -> err_o pulse; then drains x8, then x9.
REQ-029 SHALL cover forwarding: x9 buffered with 0xDEAD, raddr_a_i=9, rf_rdata_a_i=0 -> rdata_a_o=0xDEAD (macro defined); hazard_o=1, rdata_a_o=0 (macro undefined).
REQ-030 SHALL cover x0: ex write addr 0, data 0xFFFFFFFF -> no rf_we_o, no push; raddr_a_i=0 returns rf_rdata_a_i.
REQ-031 SHALL cover reset mid-operation: rst_ni low with 2 buffered entries -> rf_we_o=0, stall_o=0 immediately; no buffered write after release.
